// File: rtl/capture_controller.sv
// Event-driven stream capture: arm via bus, start/trigger/abort events gate a
// window of samples into a single-register output stream with post-trigger count.
module capture_controller #(
  parameter int BAW = 6,
  parameter int BDW = 32,
  parameter int SDW = 32,
  parameter int CCW = 32
) (
  input  logic           clk,
  input  logic           rst,
  output logic           bus_wready,
  input  logic           bus_wvalid,
  input  logic [BAW-1:0] bus_waddr,
  input  logic [BDW-1:0] bus_wdata,
  output logic           sti_tready,
  input  logic           sti_tvalid,
  input  logic [1:0]     sti_tevent,
  input  logic [SDW-1:0] sti_tdata,
  input  logic           sto_tready,
  output logic           sto_tvalid,
  output logic           sto_tlast,
  output logic [SDW-1:0] sto_tdata,
  output logic [1:0]     sts_state,
  output logic           sts_abort
);

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, RUN = 2'd2, POST = 2'd3} state_t;
  typedef enum logic [1:0] {EV_NONE = 2'd0, EV_START = 2'd1, EV_TRIG = 2'd2, EV_ABORT = 2'd3} event_t;

  state_t         state;
  logic [CCW-1:0] cnt;
  logic [CCW-1:0] cfg_post;
  logic           ctl_wr, cfg_wr, arm, disarm, in_xfer;

  assign bus_wready = 1'b1;
  assign sts_state  = state;
  assign ctl_wr     = bus_wvalid && (bus_waddr == BAW'(0));
  assign cfg_wr     = bus_wvalid && (bus_waddr == BAW'(1));
  assign arm        = ctl_wr && bus_wdata[0];
  assign disarm     = ctl_wr && bus_wdata[1];
  assign in_xfer    = sti_tvalid && sti_tready;

  always_comb begin
    sti_tready = 1'b1;
    if (state == RUN || state == POST)
      sti_tready = ~sto_tvalid | sto_tready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sto_tvalid <= 1'b0;
      sto_tlast  <= 1'b0;
      sto_tdata  <= '0;
      sts_abort  <= 1'b0;
      cnt        <= '0;
      cfg_post   <= '0;
    end else begin
      // Drain first; a forward below in the same cycle overrides the clear.
      if (sto_tvalid && sto_tready)
        sto_tvalid <= 1'b0;
      if (cfg_wr)
        cfg_post <= bus_wdata[CCW-1:0];

      if (disarm) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (arm) begin
              state     <= ARMED;
              sts_abort <= 1'b0;
            end
          end
          ARMED: begin
            if (in_xfer) begin
              if (sti_tevent == EV_START) begin
                sto_tvalid <= 1'b1;
                sto_tdata  <= sti_tdata;
                sto_tlast  <= 1'b0;
                state      <= RUN;
              end else if (sti_tevent == EV_ABORT) begin
                sts_abort <= 1'b1;
                state     <= IDLE;
              end
            end
          end
          RUN: begin
            if (in_xfer) begin
              sto_tvalid <= 1'b1;
              sto_tdata  <= sti_tdata;
              sto_tlast  <= 1'b0;
              if (sti_tevent == EV_ABORT) begin
                sto_tlast <= 1'b1;
                sts_abort <= 1'b1;
                state     <= IDLE;
              end else if (sti_tevent == EV_TRIG) begin
                if (cfg_post == '0) begin
                  sto_tlast <= 1'b1;
                  state     <= IDLE;
                end else begin
                  cnt   <= cfg_post;
                  state <= POST;
                end
              end
            end
          end
          POST: begin
            if (in_xfer) begin
              sto_tvalid <= 1'b1;
              sto_tdata  <= sti_tdata;
              sto_tlast  <= 1'b0;
              if (sti_tevent == EV_ABORT) begin
                sto_tlast <= 1'b1;
                sts_abort <= 1'b1;
                state     <= IDLE;
              end else begin
                cnt <= cnt - 1'b1;
                if (cnt == CCW'(1)) begin
                  sto_tlast <= 1'b1;
                  state     <= IDLE;
                end
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_capture_controller.sv
// Directed bench for capture_controller: capture windows, abort, backpressure,
// disarm while a beat is pending, and reset mid-capture.
module tb_capture_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bus_wready;
  logic        bus_wvalid = 1'b0;
  logic [5:0]  bus_waddr = '0;
  logic [31:0] bus_wdata = '0;
  logic        sti_tready;
  logic        sti_tvalid = 1'b0;
  logic [1:0]  sti_tevent = '0;
  logic [31:0] sti_tdata = '0;
  logic        sto_tready = 1'b1;
  logic        sto_tvalid;
  logic        sto_tlast;
  logic [31:0] sto_tdata;
  logic [1:0]  sts_state;
  logic        sts_abort;

  int errors = 0;
  int checks = 0;

  capture_controller #(.BAW(6), .BDW(32), .SDW(32), .CCW(32)) dut (
    .clk(clk), .rst(rst),
    .bus_wready(bus_wready), .bus_wvalid(bus_wvalid), .bus_waddr(bus_waddr), .bus_wdata(bus_wdata),
    .sti_tready(sti_tready), .sti_tvalid(sti_tvalid), .sti_tevent(sti_tevent), .sti_tdata(sti_tdata),
    .sto_tready(sto_tready), .sto_tvalid(sto_tvalid), .sto_tlast(sto_tlast), .sto_tdata(sto_tdata),
    .sts_state(sts_state), .sts_abort(sts_abort)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    bus_wvalid = 1'b1; bus_waddr = a; bus_wdata = d;
    tick();
    bus_wvalid = 1'b0;
  endtask

  task automatic beat(input logic [1:0] ev, input logic [31:0] d);
    sti_tvalid = 1'b1; sti_tevent = ev; sti_tdata = d;
    tick();
    sti_tvalid = 1'b0; sti_tevent = 2'd0;
  endtask

  task automatic out(input string tag, input logic [31:0] d, input logic last);
    check({tag, "_valid"}, 32'(sto_tvalid), 32'd1);
    check({tag, "_data"}, sto_tdata, d);
    check({tag, "_last"}, 32'(sto_tlast), 32'(last));
  endtask

  initial begin
    tick(); tick();
    rst = 1'b0;
    check("rst_state", 32'(sts_state), 32'd0);
    check("rst_valid", 32'(sto_tvalid), 32'd0);
    check("rst_last", 32'(sto_tlast), 32'd0);
    check("rst_data", sto_tdata, 32'd0);
    check("rst_abort", 32'(sts_abort), 32'd0);
    check("rst_wready", 32'(bus_wready), 32'd1);
    check("rst_tready", 32'(sti_tready), 32'd1);

    // cfg_post=3 window; cfg_post rewritten mid-POST must not matter
    wr(6'd1, 32'd3);
    wr(6'd0, 32'd1);
    check("w1_armed", 32'(sts_state), 32'd1);
    beat(2'd0, 32'hA0);
    check("w1_none_drop", 32'(sto_tvalid), 32'd0);
    beat(2'd1, 32'hD1); out("w1_d1", 32'hD1, 1'b0);
    check("w1_run", 32'(sts_state), 32'd2);
    beat(2'd0, 32'hD2); out("w1_d2", 32'hD2, 1'b0);
    beat(2'd2, 32'hD3); out("w1_d3", 32'hD3, 1'b0);
    check("w1_post", 32'(sts_state), 32'd3);
    beat(2'd0, 32'hD4); out("w1_d4", 32'hD4, 1'b0);
    bus_wvalid = 1'b1; bus_waddr = 6'd1; bus_wdata = 32'd9;
    beat(2'd0, 32'hD5);
    bus_wvalid = 1'b0;
    out("w1_d5", 32'hD5, 1'b0);
    beat(2'd0, 32'hD6); out("w1_d6", 32'hD6, 1'b1);
    check("w1_idle", 32'(sts_state), 32'd0);
    beat(2'd0, 32'hD7);
    check("w1_d7_drop", 32'(sto_tvalid), 32'd0);

    // cfg_post=0: trigger beat is the last
    wr(6'd1, 32'd0);
    wr(6'd0, 32'd1);
    beat(2'd1, 32'hAA); out("w2_a", 32'hAA, 1'b0);
    beat(2'd2, 32'hBB); out("w2_b", 32'hBB, 1'b1);
    check("w2_idle", 32'(sts_state), 32'd0);

    // abort in RUN
    wr(6'd0, 32'd1);
    beat(2'd1, 32'h1A); out("ab_a", 32'h1A, 1'b0);
    beat(2'd0, 32'h1B); out("ab_b", 32'h1B, 1'b0);
    beat(2'd3, 32'h1C); out("ab_c", 32'h1C, 1'b1);
    check("ab_flag", 32'(sts_abort), 32'd1);
    check("ab_idle", 32'(sts_state), 32'd0);
    tick();
    check("ab_drained", 32'(sto_tvalid), 32'd0);
    wr(6'd0, 32'd1);
    check("ab_clear", 32'(sts_abort), 32'd0);
    check("ab_rearm", 32'(sts_state), 32'd1);

    // backpressure in RUN
    sto_tready = 1'b0;
    beat(2'd1, 32'hE1); out("bp_e1", 32'hE1, 1'b0);
    check("bp_stall_rdy", 32'(sti_tready), 32'd0);
    sti_tvalid = 1'b1; sti_tevent = 2'd0; sti_tdata = 32'hE2;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_data", sto_tdata, 32'hE1);
      check("bp_hold_rdy", 32'(sti_tready), 32'd0);
    end
    sto_tready = 1'b1;
    #1;
    check("bp_release_rdy", 32'(sti_tready), 32'd1);
    tick(); out("bp_e2", 32'hE2, 1'b0);
    sti_tdata = 32'hE3;
    tick(); out("bp_e3", 32'hE3, 1'b0);
    sti_tvalid = 1'b0;
    wr(6'd0, 32'd2);
    check("bp_disarm", 32'(sts_state), 32'd0);
    check("bp_drained", 32'(sto_tvalid), 32'd0);

    // disarm wins over arm; disarm in POST with a pending beat
    wr(6'd0, 32'd1);
    check("da_armed", 32'(sts_state), 32'd1);
    wr(6'd0, 32'd3);
    check("da_wins", 32'(sts_state), 32'd0);
    wr(6'd1, 32'd4);
    wr(6'd0, 32'd1);
    beat(2'd1, 32'hF1);
    beat(2'd2, 32'hF2);
    check("da_post", 32'(sts_state), 32'd3);
    sto_tready = 1'b0;
    wr(6'd0, 32'd2);
    check("da_idle", 32'(sts_state), 32'd0);
    out("da_pending", 32'hF2, 1'b0);
    sto_tready = 1'b1;
    tick();
    check("da_drain", 32'(sto_tvalid), 32'd0);
    beat(2'd0, 32'hF4);
    check("da_drop", 32'(sto_tvalid), 32'd0);

    // reset in POST with a pending beat
    wr(6'd1, 32'd5);
    wr(6'd0, 32'd1);
    beat(2'd1, 32'h61);
    beat(2'd2, 32'h62);
    check("rs_post", 32'(sts_state), 32'd3);
    check("rs_pending", 32'(sto_tvalid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rs_valid", 32'(sto_tvalid), 32'd0);
    check("rs_state", 32'(sts_state), 32'd0);
    wr(6'd0, 32'd1);
    beat(2'd1, 32'h71); out("rs_h1", 32'h71, 1'b0);
    beat(2'd2, 32'h72); out("rs_cfg0", 32'h72, 1'b1);
    check("rs_cfg0_idle", 32'(sts_state), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
